// File: rtl/mdu_pkg.sv
// mdu_pkg
// Shared definitions for the multiply/divide unit: the ALUControl codes the
// unit responds to, the iteration count of the core, the counter width and
// the FSM state encoding.
package mdu_pkg;

  localparam int ALU_MULT  = 9;
  localparam int ALU_DIV   = 10;
  localparam int ALU_MULTU = 12;
  localparam int ALU_DIVU  = 13;

  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = $clog2(ITER_COUNT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_step.sv
// mdu_iter_step
// One combinational iteration of the multiply/divide core.
//   acc_i     : 2*DATA_WIDTH accumulator {upper, lower}
//   operand_i : multiplicand (multiply) or divisor (divide)
//   isDiv_i   : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_o     : next accumulator (divide: quotient bit slot left at 0)
//   qBit_o    : quotient bit produced by a divide step (0 for multiply)
module mdu_iter_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2*DATA_WIDTH-1:0] acc_i,
  input  logic [DATA_WIDTH-1:0]   operand_i,
  input  logic                    isDiv_i,
  output logic [2*DATA_WIDTH-1:0] acc_o,
  output logic                    qBit_o
);

  logic [DATA_WIDTH-1:0] addend;
  logic [DATA_WIDTH:0]   addSum;
  logic [DATA_WIDTH:0]   remShift;
  logic [DATA_WIDTH:0]   trialDiff;

  // Multiply: the low half holds the unconsumed multiplier bits; add the
  // multiplicand into the upper half when the current bit is set and shift
  // the whole accumulator right, keeping the carry as the new top bit.
  // Divide: the low half holds the unconsumed dividend bits; shift the
  // partial remainder left by one, trial-subtract the divisor and keep the
  // difference only when it did not borrow (restoring division).
  always_comb begin
    addend    = acc_i[0] ? operand_i : '0;
    addSum    = {1'b0, acc_i[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, addend};
    remShift  = acc_i[2*DATA_WIDTH-1:DATA_WIDTH-1];
    trialDiff = remShift - {1'b0, operand_i};
    qBit_o    = 1'b0;
    acc_o     = {addSum, acc_i[DATA_WIDTH-1:1]};
    if (isDiv_i) begin
      qBit_o = ~trialDiff[DATA_WIDTH];
      acc_o  = {(qBit_o ? trialDiff[DATA_WIDTH-1:0] : remShift[DATA_WIDTH-1:0]),
                acc_i[DATA_WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Ops (ALUControl): 9 mult, 10 div, 12 multu, 13 divu. Operands are reduced
// to magnitudes on the accepting edge, an unsigned core runs 32 iterations,
// and a final SIGN cycle applies sign correction and writes HI/LO.
// Ports:
//   CLK, RST (async, active low)
//   Start, ALUControl, SrcA, SrcB : operation request (sampled in IDLE)
//   HI_WE, LO_WE, WrData          : mthi/mtlo writes (IDLE only)
//   Busy, Done, DivByZero         : status; Done/DivByZero are 1-cycle pulses
//   HI, LO                        : architectural result registers
// Build option: define MDU_EARLY_TERM_EN to end multiplies as soon as the
// remaining multiplier bits are all zero.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int ALUControl_width = 5
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        Start,
  input  logic [ALUControl_width-1:0] ALUControl,
  input  logic [DATA_WIDTH-1:0]       SrcA,
  input  logic [DATA_WIDTH-1:0]       SrcB,
  input  logic                        HI_WE,
  input  logic                        LO_WE,
  input  logic [DATA_WIDTH-1:0]       WrData,
  output logic                        Busy,
  output logic                        Done,
  output logic                        DivByZero,
  output logic [DATA_WIDTH-1:0]       HI,
  output logic [DATA_WIDTH-1:0]       LO
);

  mdu_state_e              state_q, state_d;
  logic [CNT_W-1:0]        iterCnt_q, iterCnt_d;
  logic [2*DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0]   operand_q, operand_d;
  logic [DATA_WIDTH-1:0]   rawA_q, rawA_d;
  logic                    isDiv_q, isDiv_d;
  logic                    negRes_q, negRes_d;
  logic                    negRem_q, negRem_d;
  logic                    divZero_q, divZero_d;
  logic [DATA_WIDTH-1:0]   hi_q, hi_d;
  logic [DATA_WIDTH-1:0]   lo_q, lo_d;
  logic                    done_q, done_d;
  logic                    dbz_q, dbz_d;
`ifdef MDU_EARLY_TERM_EN
  logic [DATA_WIDTH-1:0]   mplRem_q, mplRem_d;
  logic [CNT_W-1:0]        shiftAmt;
`endif

  logic                    opMult, opDiv, opMultu, opDivu;
  logic                    opValid, opSigned, opIsDiv;
  logic                    aNeg, bNeg;
  logic [DATA_WIDTH-1:0]   absA, absB;
  logic [2*DATA_WIDTH-1:0] stepAcc, nextAcc;
  logic                    qBit;
  logic [2*DATA_WIDTH-1:0] prodMag, prodRes;
  logic [DATA_WIDTH-1:0]   quot, rem;

  // Decode the request and reduce signed operands to magnitudes so the
  // core only ever sees unsigned values.
  always_comb begin
    opMult   = (ALUControl == ALUControl_width'(ALU_MULT));
    opDiv    = (ALUControl == ALUControl_width'(ALU_DIV));
    opMultu  = (ALUControl == ALUControl_width'(ALU_MULTU));
    opDivu   = (ALUControl == ALUControl_width'(ALU_DIVU));
    opValid  = opMult | opDiv | opMultu | opDivu;
    opSigned = opMult | opDiv;
    opIsDiv  = opDiv | opDivu;
    aNeg     = opSigned & SrcA[DATA_WIDTH-1];
    bNeg     = opSigned & SrcB[DATA_WIDTH-1];
    absA     = aNeg ? -SrcA : SrcA;
    absB     = bNeg ? -SrcB : SrcB;
  end

  mdu_iter_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .acc_i    (acc_q),
    .operand_i(operand_q),
    .isDiv_i  (isDiv_q),
    .acc_o    (stepAcc),
    .qBit_o   (qBit)
  );

  // The step module leaves the quotient slot empty; drop the bit in here
  // so the low half of the accumulator fills up with the quotient.
  always_comb begin
    nextAcc = isDiv_q ? {stepAcc[2*DATA_WIDTH-1:1], qBit} : stepAcc;
  end

  // Final result shaping. An early-terminated multiply has only been
  // shifted right by the number of iterations run, so the product must be
  // realigned by the iterations that were skipped.
  always_comb begin
`ifdef MDU_EARLY_TERM_EN
    shiftAmt = CNT_W'(ITER_COUNT) - iterCnt_q;
    prodMag  = acc_q >> shiftAmt;
`else
    prodMag  = acc_q;
`endif
    prodRes = negRes_q ? -prodMag : prodMag;
    quot    = negRes_q ? -acc_q[DATA_WIDTH-1:0] : acc_q[DATA_WIDTH-1:0];
    rem     = negRem_q ? -acc_q[2*DATA_WIDTH-1:DATA_WIDTH]
                       : acc_q[2*DATA_WIDTH-1:DATA_WIDTH];
  end

  // Next-state and datapath logic. IDLE services mthi/mtlo and accepts a
  // valid request (the write still lands on the accepting edge and is later
  // overwritten by the result). CALC runs one core iteration per cycle.
  // SIGN commits HI/LO and raises the one-cycle Done pulse; a divide by
  // zero commits all-ones / the raw dividend instead of the core result.
  always_comb begin
    state_d   = state_q;
    iterCnt_d = iterCnt_q;
    acc_d     = acc_q;
    operand_d = operand_q;
    rawA_d    = rawA_q;
    isDiv_d   = isDiv_q;
    negRes_d  = negRes_q;
    negRem_d  = negRem_q;
    divZero_d = divZero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
`ifdef MDU_EARLY_TERM_EN
    mplRem_d  = mplRem_q;
`endif
    case (state_q)
      IDLE: begin
        if (HI_WE) hi_d = WrData;
        if (LO_WE) lo_d = WrData;
        if (Start && opValid) begin
          state_d   = CALC;
          iterCnt_d = '0;
          rawA_d    = SrcA;
          isDiv_d   = opIsDiv;
          negRes_d  = aNeg ^ bNeg;
          negRem_d  = aNeg;
          divZero_d = opIsDiv && (SrcB == '0);
          if (opIsDiv) begin
            acc_d     = {{DATA_WIDTH{1'b0}}, absA};
            operand_d = absB;
          end else begin
            acc_d     = {{DATA_WIDTH{1'b0}}, absB};
            operand_d = absA;
          end
`ifdef MDU_EARLY_TERM_EN
          mplRem_d = absB;
          if (!opIsDiv && (absB == '0)) state_d = SIGN;
`endif
        end
      end
      CALC: begin
        acc_d     = nextAcc;
        iterCnt_d = iterCnt_q + 1'b1;
        if (iterCnt_q == CNT_W'(ITER_COUNT - 1)) state_d = SIGN;
`ifdef MDU_EARLY_TERM_EN
        mplRem_d = mplRem_q >> 1;
        if (!isDiv_q && ((mplRem_q >> 1) == '0)) state_d = SIGN;
`endif
      end
      SIGN: begin
        state_d = IDLE;
        done_d  = 1'b1;
        dbz_d   = divZero_q;
        if (divZero_q) begin
          hi_d = rawA_q;
          lo_d = '1;
        end else if (isDiv_q) begin
          hi_d = rem;
          lo_d = quot;
        end else begin
          hi_d = prodRes[2*DATA_WIDTH-1:DATA_WIDTH];
          lo_d = prodRes[DATA_WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any operation in flight and clears
  // HI/LO without producing a Done pulse.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      iterCnt_q <= '0;
      acc_q     <= '0;
      operand_q <= '0;
      rawA_q    <= '0;
      isDiv_q   <= 1'b0;
      negRes_q  <= 1'b0;
      negRem_q  <= 1'b0;
      divZero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
`ifdef MDU_EARLY_TERM_EN
      mplRem_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      iterCnt_q <= iterCnt_d;
      acc_q     <= acc_d;
      operand_q <= operand_d;
      rawA_q    <= rawA_d;
      isDiv_q   <= isDiv_d;
      negRes_q  <= negRes_d;
      negRem_q  <= negRem_d;
      divZero_q <= divZero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
`ifdef MDU_EARLY_TERM_EN
      mplRem_q  <= mplRem_d;
`endif
    end
  end

  assign Busy      = (state_q != IDLE);
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
// Directed, table-driven bench for mult_div_unit plus hand-written
// sequences for mthi/mtlo handling, ignored requests and reset mid-op.
module tb_mult_div_unit;

  logic        CLK;
  logic        RST;
  logic        Start;
  logic [4:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        HI_WE;
  logic        LO_WE;
  logic [31:0] WrData;
  logic        Busy;
  logic        Done;
  logic        DivByZero;
  logic [31:0] HI;
  logic [31:0] LO;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [4:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    logic        expDbz;
  } vec_t;

  vec_t vecs[14];

  mult_div_unit #(
    .DATA_WIDTH      (32),
    .ALUControl_width(5)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Start     (Start),
    .ALUControl(ALUControl),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .HI_WE     (HI_WE),
    .LO_WE     (LO_WE),
    .WrData    (WrData),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero),
    .HI        (HI),
    .LO        (LO)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Cycles from the Start edge to Done, counting the Start edge and the
  // SIGN edge, as seen by the pipeline.
  function automatic int expLatency(input logic [4:0] ctrl, input logic [31:0] b);
    int lat;
`ifdef MDU_EARLY_TERM_EN
    logic [31:0] mag;
`endif
    lat = 34;
`ifdef MDU_EARLY_TERM_EN
    mag = (ctrl == 5'd9 && b[31]) ? -b : b;
    if (ctrl == 5'd9 || ctrl == 5'd12) begin
      lat = 2;
      for (int i = 0; i < 32; i++) if (mag[i]) lat = i + 3;
    end
`endif
    return lat;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait for Done with a cycle bound. j is the number of edges after the
  // Start edge already seen; lat is returned in Start-edge-inclusive cycles
  // (-1 on timeout). Busy is counted in every cycle before Done.
  task automatic waitDone(input int startJ, output int lat, output int busyCnt, output logic dbz);
    int j;
    j       = startJ;
    busyCnt = 0;
    lat     = -1;
    dbz     = 1'b0;
    while (!Done && j < 80) begin
      if (Busy) busyCnt++;
      @(posedge CLK); #1;
      j++;
    end
    if (Done) begin
      lat = j + 1;
      dbz = DivByZero;
    end
  endtask

  task automatic applyStimulus(input logic [4:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                               output int lat, output int busyCnt, output logic dbz);
    @(negedge CLK);
    Start      = 1'b1;
    ALUControl = ctrl;
    SrcA       = a;
    SrcB       = b;
    @(posedge CLK); #1;
    Start = 1'b0;
    waitDone(0, lat, busyCnt, dbz);
  endtask

  initial begin
    int          lat;
    int          busyCnt;
    logic        dbz;
    logic        sawDone;
    int          expLat;

    vecs[0]  = '{"multu_ff_ff",  5'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{"mult_m3_7",    5'd9,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{"div_m7_2",     5'd10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{"div_ovf",      5'd10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[4]  = '{"divu_by0",     5'd13, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{"divu_50_7",    5'd13, 32'd50,       32'd7,        32'd1,        32'd7,        1'b0};
    vecs[6]  = '{"div_7_m2",     5'd10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[7]  = '{"div_m7_m2",    5'd10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};
    vecs[8]  = '{"mult_max_2",   5'd9,  32'h7FFFFFFF, 32'd2,        32'h00000000, 32'hFFFFFFFE, 1'b0};
    vecs[9]  = '{"mult_m1_m1",   5'd9,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[10] = '{"multu_x_0",    5'd12, 32'h12345678, 32'd0,        32'h00000000, 32'h00000000, 1'b0};
    vecs[11] = '{"div_m5_by0",   5'd10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
    vecs[12] = '{"multu_2p32",   5'd12, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
    vecs[13] = '{"divu_max_10",  5'd13, 32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999, 1'b0};

    RST        = 1'b0;
    Start      = 1'b0;
    ALUControl = '0;
    SrcA       = '0;
    SrcB       = '0;
    HI_WE      = 1'b0;
    LO_WE      = 1'b0;
    WrData     = '0;

    #3;
    checkOutput("reset.hi",   64'(HI),        64'h0);
    checkOutput("reset.lo",   64'(LO),        64'h0);
    checkOutput("reset.busy", 64'(Busy),      64'h0);
    checkOutput("reset.done", 64'(Done),      64'h0);
    checkOutput("reset.dbz",  64'(DivByZero), 64'h0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;

    // Table-driven operations
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].ctrl, vecs[i].a, vecs[i].b, lat, busyCnt, dbz);
      expLat = expLatency(vecs[i].ctrl, vecs[i].b);
      checkOutput({vecs[i].name, ".hi"},   64'(HI),      64'(vecs[i].expHi));
      checkOutput({vecs[i].name, ".lo"},   64'(LO),      64'(vecs[i].expLo));
      checkOutput({vecs[i].name, ".dbz"},  64'(dbz),     64'(vecs[i].expDbz));
      checkOutput({vecs[i].name, ".lat"},  64'(lat),     64'(expLat));
      checkOutput({vecs[i].name, ".busy"}, 64'(busyCnt), 64'(expLat - 1));
      @(posedge CLK); #1;
      checkOutput({vecs[i].name, ".done_pulse"}, 64'(Done),      64'h0);
      checkOutput({vecs[i].name, ".dbz_pulse"},  64'(DivByZero), 64'h0);
      checkOutput({vecs[i].name, ".idle"},       64'(Busy),      64'h0);
    end

    // mthi in IDLE, then both enables together
    @(negedge CLK);
    HI_WE  = 1'b1;
    WrData = 32'h00001234;
    @(negedge CLK);
    HI_WE  = 1'b0;
    checkOutput("mthi.hi", 64'(HI), 64'h1234);
    HI_WE  = 1'b1;
    LO_WE  = 1'b1;
    WrData = 32'h0000ABCD;
    @(negedge CLK);
    HI_WE  = 1'b0;
    LO_WE  = 1'b0;
    checkOutput("mthilo.hi", 64'(HI), 64'hABCD);
    checkOutput("mthilo.lo", 64'(LO), 64'hABCD);

    // Start with an unsupported code is ignored
    Start      = 1'b1;
    ALUControl = 5'd0;
    SrcA       = 32'd3;
    SrcB       = 32'd5;
    @(negedge CLK);
    Start = 1'b0;
    checkOutput("badop.busy", 64'(Busy), 64'h0);
    @(negedge CLK);
    checkOutput("badop.busy2", 64'(Busy), 64'h0);
    checkOutput("badop.done",  64'(Done), 64'h0);

    // multu 3*5 with an mtlo on the accepting edge, then Start/LO_WE while busy
    Start      = 1'b1;
    ALUControl = 5'd12;
    SrcA       = 32'd3;
    SrcB       = 32'd5;
    LO_WE      = 1'b1;
    WrData     = 32'h00005555;
    @(posedge CLK); #1;
    Start = 1'b0;
    LO_WE = 1'b0;
    checkOutput("startwr.lo", 64'(LO), 64'h5555);
    checkOutput("startwr.busy", 64'(Busy), 64'h1);
    @(negedge CLK);
    Start      = 1'b1;
    ALUControl = 5'd13;
    SrcA       = 32'd77;
    SrcB       = 32'd0;
    LO_WE      = 1'b1;
    WrData     = 32'h0000DEAD;
    @(posedge CLK); #1;
    Start = 1'b0;
    LO_WE = 1'b0;
    waitDone(1, lat, busyCnt, dbz);
    checkOutput("busyign.hi",  64'(HI),  64'h0);
    checkOutput("busyign.lo",  64'(LO),  64'd15);
    checkOutput("busyign.dbz", 64'(dbz), 64'h0);
    checkOutput("busyign.lat", 64'(lat), 64'(expLatency(5'd12, 32'd5)));
    sawDone = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge CLK); #1;
      if (Busy || Done) sawDone = 1'b1;
    end
    checkOutput("busyign.nosecond", 64'(sawDone), 64'h0);

    // Reset in the middle of a divide
    @(negedge CLK);
    Start      = 1'b1;
    ALUControl = 5'd13;
    SrcA       = 32'd50;
    SrcB       = 32'd7;
    @(posedge CLK); #1;
    Start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(posedge CLK); #1;
    end
    checkOutput("midrst.busy_before", 64'(Busy), 64'h1);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checkOutput("midrst.hi",   64'(HI),   64'h0);
    checkOutput("midrst.lo",   64'(LO),   64'h0);
    checkOutput("midrst.busy", 64'(Busy), 64'h0);
    sawDone = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      if (Done) sawDone = 1'b1;
    end
    @(negedge CLK);
    RST = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge CLK); #1;
      if (Done) sawDone = 1'b1;
    end
    checkOutput("midrst.nodone", 64'(sawDone), 64'h0);

    applyStimulus(5'd13, 32'd50, 32'd7, lat, busyCnt, dbz);
    checkOutput("afterrst.hi",  64'(HI),  64'd1);
    checkOutput("afterrst.lo",  64'(LO),  64'd7);
    checkOutput("afterrst.lat", 64'(lat), 64'd34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit (MDU) that consumes the 5-bit ALUControl codes produced by the ALU decoder for mult (9), div (10), multu (12) and divu (13).
- Owns the architectural HI/LO registers and services mthi/mtlo writes.
- Sits beside the main ALU in the execute datapath. The control FSM holds the pipeline while busy=1.

Parameters:
- DATA_WIDTH, 32: operand and HI/LO width.
- ALUControl_width, 5: width of the ALUControl input.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous active-low reset.
- Start  input  1  request; sampled only in IDLE.
- ALUControl  input  ALUControl_width  operation code: 9 mult, 10 div, 12 multu, 13 divu.
- SrcA  input  DATA_WIDTH  multiplicand / dividend.
- SrcB  input  DATA_WIDTH  multiplier / divisor.
- HI_WE  input  1  mthi write enable.
- LO_WE  input  1  mtlo write enable.
- WrData  input  DATA_WIDTH  mthi/mtlo data.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle pulse when HI/LO are updated by an operation.
- DivByZero  output  1  pulses together with Done when a div/divu had SrcB==0.
- HI  output  DATA_WIDTH  HI register.
- LO  output  DATA_WIDTH  LO register.

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE; HI=0, LO=0, Busy=0, Done=0, DivByZero=0; iteration counter=0.
- States:
  - IDLE -> CALC on Start=1 with ALUControl in {9,10,12,13}. Operands and op are latched on that edge (E0).
  - Start with any other code is ignored.
  - CALC: one iteration per cycle, 32 iterations (E1..E32), then SIGN.
  - SIGN: one edge (E33). Applies sign correction, writes HI/LO, registers Done=1, returns to IDLE.
- Latency: Busy=1 in the cycles after E0 through E33. Done=1 for exactly the one cycle after E33, fixed at 34 cycles from the Start edge.
- Signed ops (9, 10):
  - Operands are converted to magnitude at E0 and the unsigned core is run.
  - mult: the 64-bit product is negated if the operand signs differ.
  - div: the quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
- Multiply: shift-add over 64-bit {HI,LO}. Final HI = product[63:32], LO = product[31:0].
- Divide: restoring, one quotient bit per iteration. LO = quotient, HI = remainder.
- Divide by zero (SrcB==0 at E0):
  - Runs full latency.
  - Result LO=all-ones, HI=SrcA as latched (raw, no sign fix).
  - DivByZero=1 with Done.
- Overflow: div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. No flag.
- Start while Busy: ignored; the in-flight op is unaffected.
- HI_WE/LO_WE:
  - Honoured only in IDLE; ignored while Busy.
  - In IDLE, a write coinciding with an accepted Start still takes effect on that edge; the operation result overwrites it at E33.
  - Both HI_WE and LO_WE asserted writes WrData to both registers.
- Done and DivByZero are registered and low in every other cycle.
- Reset mid-operation: immediate IDLE. HI/LO are cleared; no Done is produced.

Optional Feature:
- MDU_EARLY_TERM_EN defined:
  - In CALC for mult/multu, when the remaining unshifted multiplier bits are all zero, go to SIGN on the next edge.
  - Latency = (index of highest set bit of |SrcB|)+1 iterations + 2 edges.
  - SrcB==0 gives 0 iterations.
  - Divide latency is unchanged.
- Undefined: fixed 34-cycle latency for all ops.

Decomposition:
- Shared package mdu_pkg:
  - localparams ALU_MULT=9, ALU_DIV=10, ALU_MULTU=12, ALU_DIVU=13.
  - State encoding IDLE/CALC/SIGN.
  - ITER_COUNT=32.
- Sub-module mdu_iter_step: combinational single iteration, either shift-add or trial-subtract. It takes accumulator, operand and op-is-div, and returns the next accumulator plus the quotient bit.
- Top level holds the FSM, counter, sign handling and HI/LO.

Test Plan:
1. multu SrcA=0xFFFFFFFF, SrcB=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Done exactly 34 cycles after the Start edge; Busy high for 33 cycles.
2. mult SrcA=0xFFFFFFFD (-3), SrcB=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. With MDU_EARLY_TERM_EN, Done arrives 5 cycles after Start.
3. div SrcA=0xFFFFFFF9 (-7), SrcB=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
4. divu SrcA=100, SrcB=0 -> LO=0xFFFFFFFF, HI=100, DivByZero=1 for one cycle with Done.
5. Idle and busy control sequence:
   - In IDLE, HI_WE=1, WrData=0x1234 -> HI=0x1234.
   - Start with ALUControl=0 -> Busy stays 0.
   - Start multu 3*5; during Busy apply Start (divu) and LO_WE -> both ignored; HI=0, LO=15.
6. Start divu 50/7; assert RST=0 at cycle 10 -> HI=LO=0 and Busy=0 immediately; no Done pulse. After release, a new op completes normally.
